// File: rtl/fib_seq_ram_gen_if.sv
// rtl/fib_seq_ram_gen_if.sv - control, status and read-port bundle for the recurrence RAM generator
interface fib_seq_ram_gen_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W:0]   num;
  logic [WIDTH-1:0]  seed_a;
  logic [WIDTH-1:0]  seed_b;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [ADDR_W:0]   count;

  modport master (
    output start, num, seed_a, seed_b, rd_addr,
    input  rd_data, busy, done, ovf, count
  );

  modport slave (
    input  start, num, seed_a, seed_b, rd_addr,
    output rd_data, busy, done, ovf, count
  );
endinterface

// File: rtl/fib_seq_ram_gen.sv
// rtl/fib_seq_ram_gen.sv - writes n terms of t(i)=t(i-1)+t(i-2) into a RAM, saturating on overflow
module fib_seq_ram_gen #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic              clk,
  input logic              rst,
  fib_seq_ram_gen_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_N   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  seed_a_q, seed_b_q, prev_q, cur_q, term, rd_data_q;
  logic [WIDTH:0]    sum;
  logic [ADDR_W:0]   n_q, n_in, count_q, count_inc;
  logic              ovf_q, accept, sat, we, busy, done;

  assign n_in      = (bus.num > DEPTH_N) ? DEPTH_N : bus.num;
  assign accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign count_inc = count_q + ONE_N;
  assign sum       = {1'b0, prev_q} + {1'b0, cur_q};

  // Seeds bypass the adder; a saturated operand can only produce another saturated term.
  always_comb begin
    sat  = 1'b0;
    term = sum[WIDTH-1:0];
    if (count_q == '0) begin
      term = seed_a_q;
    end else if (count_q == ONE_N) begin
      term = seed_b_q;
    end else if (sum[WIDTH]) begin
      term = '1;
      sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: if (accept) state_d = (n_in == '0) ? S_FIN : S_RUN;
      S_RUN:         if (count_inc == n_q) state_d = S_FIN;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_FIN);
    we   = (state_q == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_a_q <= '0;
      seed_b_q <= '0;
      prev_q   <= '0;
      cur_q    <= '0;
      n_q      <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      seed_a_q <= bus.seed_a;
      seed_b_q <= bus.seed_b;
      n_q      <= n_in;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (we) begin
      count_q  <= count_inc;
      prev_q   <= cur_q;
      cur_q    <= term;
      ovf_q    <= ovf_q | sat;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[count_q[ADDR_W-1:0]] <= term;
  end

  // Read-first: a same-edge write to rd_addr is seen on the following read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.ovf     = ovf_q;
  assign bus.count   = count_q;
endmodule

// File: tb/tb_fib_seq_ram_gen.sv
// tb/tb_fib_seq_ram_gen.sv - directed vector bench for fib_seq_ram_gen at WIDTH 16 and 8
module tb_fib_seq_ram_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fib_seq_ram_gen_if #(.WIDTH(16), .ADDR_W(4)) if16 ();
  fib_seq_ram_gen_if #(.WIDTH(8),  .ADDR_W(4)) if8 ();

  fib_seq_ram_gen #(.WIDTH(16), .ADDR_W(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  fib_seq_ram_gen #(.WIDTH(8),  .ADDR_W(4)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));

  typedef struct {
    logic [15:0] sa, sb;
    logic [4:0]  num;
    int          pulse_at;
    int          rst_at;
    int          exp_cnt;
    int          exp_busy;
    bit          exp_ovf;
  } run_vec_t;

  typedef struct {
    int          run_idx;
    logic [3:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  run_vec_t runs[8];
  rd_vec_t  rds[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void add_rd(input int r, input int a, input int e);
    rd_vec_t v;
    v.run_idx = r;
    v.addr    = 4'(a);
    v.exp     = 16'(e);
    rds.push_back(v);
  endfunction

  task automatic rd16(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    if16.rd_addr = a;
    @(negedge clk);
    d = if16.rd_data;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    if8.rd_addr = a;
    @(negedge clk);
    d = if8.rd_data;
  endtask

  int fib[16]   = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
  int lucas[10] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76};

  initial begin
    logic [15:0] d16;
    logic [7:0]  d8;
    int          bc;
    bit          aborted;

    //              sa     sb     num  pulse rst  cnt busy ovf
    runs[0] = '{16'd0,     16'd1,     5'd16, -1, -1, 16, 16, 1'b0};
    runs[1] = '{16'd2,     16'd1,     5'd10, -1, -1, 10, 10, 1'b0};
    runs[2] = '{16'd0,     16'd0,     5'd0,  -1, -1,  0,  0, 1'b0};
    runs[3] = '{16'd0,     16'd1,     5'd20, -1, -1, 16, 16, 1'b0};
    runs[4] = '{16'd40000, 16'd30000, 5'd4,  -1, -1,  4,  4, 1'b1};
    runs[5] = '{16'd0,     16'd1,     5'd16,  4, -1, 16, 16, 1'b0};
    runs[6] = '{16'd2,     16'd1,     5'd16, -1,  6,  0,  0, 1'b0};
    runs[7] = '{16'd0,     16'd1,     5'd16, -1, -1, 16, 16, 1'b0};

    for (int i = 0; i < 16; i++) add_rd(0, i, fib[i]);
    for (int i = 0; i < 10; i++) add_rd(1, i, lucas[i]);
    for (int i = 10; i < 16; i++) add_rd(1, i, fib[i]);
    add_rd(2, 0, 2);  add_rd(2, 9, 76);  add_rd(2, 10, 55);
    add_rd(3, 0, 0);  add_rd(3, 9, 34);  add_rd(3, 15, 610);
    add_rd(4, 0, 40000); add_rd(4, 1, 30000); add_rd(4, 2, 65535);
    add_rd(4, 3, 65535); add_rd(4, 4, 3);
    add_rd(5, 5, 5);  add_rd(5, 15, 610);
    for (int i = 0; i < 6; i++) add_rd(6, i, lucas[i]);
    add_rd(6, 6, 8);  add_rd(6, 15, 610);
    add_rd(7, 7, 13); add_rd(7, 15, 610);

    if16.start = 0; if16.num = '0; if16.seed_a = '0; if16.seed_b = '0; if16.rd_addr = '0;
    if8.start  = 0; if8.num  = '0; if8.seed_a  = '0; if8.seed_b  = '0; if8.rd_addr  = '0;

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_busy",  {31'd0, if16.busy}, 0);
    chk("reset_done",  {31'd0, if16.done}, 0);
    chk("reset_ovf",   {31'd0, if16.ovf},  0);
    chk("reset_count", {27'd0, if16.count}, 0);
    chk("reset_rd",    {16'd0, if16.rd_data}, 0);
    chk("reset8_done", {31'd0, if8.done}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if16.seed_a = runs[r].sa;
      if16.seed_b = runs[r].sb;
      if16.num    = runs[r].num;
      if16.start  = 1'b1;
      @(negedge clk);
      if16.start = 1'b0;
      bc = 0;
      aborted = 0;
      for (int k = 0; k < 40; k++) begin
        if (!if16.busy) break;
        bc++;
        if16.start = (k == runs[r].pulse_at);
        if (k == runs[r].rst_at) begin
          rst = 1'b1;
          #1;
          chk($sformatf("run%0d_rst_busy", r),  {31'd0, if16.busy}, 0);
          chk($sformatf("run%0d_rst_done", r),  {31'd0, if16.done}, 0);
          chk($sformatf("run%0d_rst_ovf", r),   {31'd0, if16.ovf},  0);
          chk($sformatf("run%0d_rst_count", r), {27'd0, if16.count}, 0);
          chk($sformatf("run%0d_rst_rd", r),    {16'd0, if16.rd_data}, 0);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1;
          break;
        end
        @(negedge clk);
      end
      if16.start = 1'b0;
      if (!aborted) begin
        chk($sformatf("run%0d_busy_cycles", r), bc, runs[r].exp_busy);
        chk($sformatf("run%0d_done", r),  {31'd0, if16.done}, 1);
        chk($sformatf("run%0d_count", r), {27'd0, if16.count}, runs[r].exp_cnt);
        chk($sformatf("run%0d_ovf", r),   {31'd0, if16.ovf}, {31'd0, runs[r].exp_ovf});
      end
      foreach (rds[j]) begin
        if (rds[j].run_idx == r) begin
          rd16(rds[j].addr, d16);
          chk($sformatf("run%0d_rd_addr%0d", r, rds[j].addr), {16'd0, d16}, {16'd0, rds[j].exp});
        end
      end
    end

    // 8-bit instance: f(14)=377 saturates, so OVF must rise exactly on the addr14 write.
    @(negedge clk);
    if8.seed_a = 8'd0; if8.seed_b = 8'd1; if8.num = 5'd16; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (!if8.busy) break;
      bc++;
      if (if8.count == 5'd14) chk("w8_ovf_before_addr14", {31'd0, if8.ovf}, 0);
      if (if8.count == 5'd15) chk("w8_ovf_at_addr14",     {31'd0, if8.ovf}, 1);
      @(negedge clk);
    end
    chk("w8_busy_cycles", bc, 16);
    chk("w8_count", {27'd0, if8.count}, 16);
    chk("w8_ovf_end", {31'd0, if8.ovf}, 1);
    rd8(4'd12, d8); chk("w8_rd_addr12", {24'd0, d8}, 144);
    rd8(4'd13, d8); chk("w8_rd_addr13", {24'd0, d8}, 233);
    rd8(4'd14, d8); chk("w8_rd_addr14", {24'd0, d8}, 255);
    rd8(4'd15, d8); chk("w8_rd_addr15", {24'd0, d8}, 255);
    chk("w8_ovf_sticky", {31'd0, if8.ovf}, 1);
    @(negedge clk);
    if8.num = 5'd2; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    chk("w8_ovf_cleared_on_accept", {31'd0, if8.ovf}, 0);
    chk("w8_busy_after_accept", {31'd0, if8.busy}, 1);
    @(negedge clk);
    @(negedge clk);
    chk("w8_short_done", {31'd0, if8.done}, 1);
    chk("w8_short_count", {27'd0, if8.count}, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
